// File: rtl/cond_logic_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cond_logic_if : execute-stage conditional-logic bus (COND_STATS_EN adds  |
// |                 ExecCnt/SquashCnt)                       rev 1.0         |
// +--------------------------------------------------------------------------+
interface cond_logic_if;
  logic       Valid;
  logic       Stall;
  logic       Flush;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       CondEx;
  logic [3:0] Flags;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       ValidOut;
`ifdef COND_STATS_EN
  logic [15:0] ExecCnt;
  logic [15:0] SquashCnt;
`endif

  modport master (
    output Valid, Stall, Flush, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, CondEx,
`ifdef COND_STATS_EN
    input  ExecCnt, SquashCnt,
`endif
    input  Flags, PCSrc, RegWrite, MemWrite, ValidOut
  );

  modport slave (
    input  Valid, Stall, Flush, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, CondEx,
`ifdef COND_STATS_EN
    output ExecCnt, SquashCnt,
`endif
    output Flags, PCSrc, RegWrite, MemWrite, ValidOut
  );
endinterface
`default_nettype wire

// File: rtl/cond_logic.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cond_logic : flag register and condition-gated write enables for the     |
// |              execute stage; COND_STATS_EN adds exec/squash counters      |
// |              rev 1.0                                                     |
// +--------------------------------------------------------------------------+
module cond_logic (
  input  logic         clk,
  input  logic         rst_n,
  cond_logic_if.slave  bus
);

  localparam logic [15:0] c_cnt_max = 16'hFFFF;

  logic       w_accept;
  logic       w_exec;
  logic [3:0] r_flags;
  logic       r_pcsrc;
  logic       r_regwrite;
  logic       r_memwrite;
  logic       r_valid_out;

  assign w_accept = bus.Valid & ~bus.Stall & ~bus.Flush;
  assign w_exec   = w_accept & bus.CondEx;

  // Flags layout is {C,N,V,Z}: FlagW[1] owns N,Z (bits 2,0), FlagW[0] owns C,V (bits 3,1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 4'b0000;
    end else if (w_exec) begin
      if (bus.FlagW[1]) begin
        r_flags[2] <= bus.ALUFlags[2];
        r_flags[0] <= bus.ALUFlags[0];
      end
      if (bus.FlagW[0]) begin
        r_flags[3] <= bus.ALUFlags[3];
        r_flags[1] <= bus.ALUFlags[1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcsrc     <= 1'b0;
      r_regwrite  <= 1'b0;
      r_memwrite  <= 1'b0;
      r_valid_out <= 1'b0;
    end else if (bus.Flush) begin
      r_pcsrc     <= 1'b0;
      r_regwrite  <= 1'b0;
      r_memwrite  <= 1'b0;
      r_valid_out <= 1'b0;
    end else if (!bus.Stall) begin
      // Valid=0 folds into the same gating and yields an all-zero bubble
      r_pcsrc     <= bus.Valid & bus.PCS  & bus.CondEx;
      r_regwrite  <= bus.Valid & bus.RegW & bus.CondEx & ~bus.NoWrite;
      r_memwrite  <= bus.Valid & bus.MemW & bus.CondEx;
      r_valid_out <= bus.Valid;
    end
  end

  assign bus.Flags    = r_flags;
  assign bus.PCSrc    = r_pcsrc;
  assign bus.RegWrite = r_regwrite;
  assign bus.MemWrite = r_memwrite;
  assign bus.ValidOut = r_valid_out;

`ifdef COND_STATS_EN
  logic [15:0] r_exec_cnt;
  logic [15:0] r_squash_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exec_cnt   <= 16'h0000;
      r_squash_cnt <= 16'h0000;
    end else begin
      if (w_exec && (r_exec_cnt != c_cnt_max))
        r_exec_cnt <= r_exec_cnt + 16'h0001;
      if (w_accept && !bus.CondEx && (r_squash_cnt != c_cnt_max))
        r_squash_cnt <= r_squash_cnt + 16'h0001;
    end
  end

  assign bus.ExecCnt   = r_exec_cnt;
  assign bus.SquashCnt = r_squash_cnt;
`else
  logic w_unused_max;
  assign w_unused_max = ^c_cnt_max;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cond_logic.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cond_logic : scoreboard bench for cond_logic (COND_STATS_EN aware)    |
// |                 rev 1.0                                                  |
// +--------------------------------------------------------------------------+
module tb_cond_logic;

  logic clk;
  logic rst_n;
  cond_logic_if bus ();

  cond_logic dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // expected {Flags[3:0], PCSrc, RegWrite, MemWrite, ValidOut}
  logic [7:0] sb_q[$];

  logic [3:0] m_flags;
  logic       m_pc, m_rw, m_mw, m_vo;
  int         m_exec, m_squash;

  task automatic model_reset();
    m_flags = 4'b0000;
    m_pc = 1'b0; m_rw = 1'b0; m_mw = 1'b0; m_vo = 1'b0;
    m_exec = 0; m_squash = 0;
  endtask

  task automatic drive(input logic v, s, f, ce, pcs, regw, memw, nw,
                       input logic [1:0] fw, input logic [3:0] af);
    logic acc;
    bus.Valid = v; bus.Stall = s; bus.Flush = f; bus.CondEx = ce;
    bus.PCS = pcs; bus.RegW = regw; bus.MemW = memw; bus.NoWrite = nw;
    bus.FlagW = fw; bus.ALUFlags = af;
    acc = v & ~s & ~f;
    if (acc & ce) begin
      if (fw[1]) begin m_flags[2] = af[2]; m_flags[0] = af[0]; end
      if (fw[0]) begin m_flags[3] = af[3]; m_flags[1] = af[1]; end
      if (m_exec < 65535) m_exec++;
    end
    if (acc & ~ce && m_squash < 65535) m_squash++;
    if (f) begin
      m_pc = 0; m_rw = 0; m_mw = 0; m_vo = 0;
    end else if (!s) begin
      if (v) begin
        m_pc = pcs & ce; m_rw = regw & ce & ~nw; m_mw = memw & ce; m_vo = 1'b1;
      end else begin
        m_pc = 0; m_rw = 0; m_mw = 0; m_vo = 0;
      end
    end
  endtask

  task automatic compare_all(input string tag, input logic [7:0] e);
    check({tag, ".flags"},    {28'd0, bus.Flags},    {28'd0, e[7:4]});
    check({tag, ".pcsrc"},    {31'd0, bus.PCSrc},    {31'd0, e[3]});
    check({tag, ".regwrite"}, {31'd0, bus.RegWrite}, {31'd0, e[2]});
    check({tag, ".memwrite"}, {31'd0, bus.MemWrite}, {31'd0, e[1]});
    check({tag, ".validout"}, {31'd0, bus.ValidOut}, {31'd0, e[0]});
  endtask

  task automatic step(input string tag, input logic v, s, f, ce, pcs, regw, memw, nw,
                      input logic [1:0] fw, input logic [3:0] af);
    logic [7:0] e;
    @(negedge clk);
    rst_n = 1'b1;
    drive(v, s, f, ce, pcs, regw, memw, nw, fw, af);
    sb_q.push_back({m_flags, m_pc, m_rw, m_mw, m_vo});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      compare_all(tag, e);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000);
    model_reset();
    #2;
    compare_all("reset_init", 8'h00);

    // N,Z load only; C,V held
    step("nz_only",   1, 0, 0, 1, 0, 0, 0, 0, 2'b10, 4'b1111);
    // failed condition is a bubble
    step("cond_fail", 1, 0, 0, 0, 1, 1, 1, 0, 2'b11, 4'b1010);
    // compare-type instruction writes flags only
    step("nowrite",   1, 0, 0, 1, 0, 1, 0, 1, 2'b11, 4'b0001);
    step("all_write", 1, 0, 0, 1, 1, 1, 1, 0, 2'b00, 4'b1111);
    // Flush beats Stall
    step("stall_flush", 1, 1, 1, 1, 1, 1, 1, 0, 2'b11, 4'b1111);
    step("cv_only",   1, 0, 0, 1, 0, 1, 0, 0, 2'b01, 4'b1010);
    for (int i = 0; i < 3; i++)
      step("stall_hold", 1, 1, 0, 1, 1, 0, 1, 0, 2'b11, 4'b0100);
    step("idle",      0, 0, 0, 1, 1, 1, 1, 0, 2'b11, 4'b0110);

    // back-to-back dependency and mixed traffic
    for (int i = 0; i < 60; i++) begin
      logic [3:0] r;
      r = 4'($urandom);
      step("random", 1'($urandom), (r == 4'd0), (r == 4'd1), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           2'($urandom), 4'($urandom));
    end

    // asynchronous reset mid-stall with all flags set
    step("set_all",   1, 0, 0, 1, 0, 1, 0, 0, 2'b11, 4'b1111);
    step("pre_rst",   1, 1, 0, 1, 0, 0, 0, 0, 2'b11, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    compare_all("async_rst", 8'h00);
    sb_q.delete();
    model_reset();
    step("post_rst",  1, 0, 0, 1, 1, 1, 0, 0, 2'b10, 4'b0101);
    step("post_rst2", 1, 0, 0, 1, 0, 0, 1, 0, 2'b01, 4'b1010);

`ifdef COND_STATS_EN
    check("squash_cnt_pre", {16'd0, bus.SquashCnt}, 32'(m_squash));
    check("exec_cnt_pre",   {16'd0, bus.ExecCnt},   32'(m_exec));
    @(negedge clk);
    drive(1, 0, 0, 1, 0, 1, 0, 0, 2'b00, 4'b0000);
    for (int i = 0; i < 70000; i++) begin
      if (m_exec < 65535) m_exec++;
      @(negedge clk);
    end
    m_exec--;  // loop counted one extra drive beyond the initial one
    check("exec_cnt_sat",   {16'd0, bus.ExecCnt},   32'h0000_FFFF);
    check("squash_cnt_sat", {16'd0, bus.SquashCnt}, 32'(m_squash));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port Valid, input, 1, execute-stage instruction present.
REQ-004 SHALL have port Stall, input, 1, hold the stage; no state changes.
REQ-005 SHALL have port Flush, input, 1, squash the current instruction.
REQ-006 SHALL have port ALUFlags, input, 4, {C,N,V,Z} from the ALU.
REQ-007 SHALL have port FlagW, input, 2, flag write enables: bit1 updates N,Z; bit0 updates C,V.
REQ-008 SHALL have port PCS, input, 1, decoded PC write.
REQ-009 SHALL have port RegW, input, 1, decoded register write.
REQ-010 SHALL have port MemW, input, 1, decoded memory write.
REQ-011 SHALL have port NoWrite, input, 1, compare-type instruction; suppresses the register write.
REQ-012 SHALL have port CondEx, input, 1, condition-pass result from the condition checker.
REQ-013 SHALL have port Flags, output, 4, stored {C,N,V,Z} driven to the condition checker.
REQ-014 SHALL have port PCSrc, output, 1, registered gated PC write.
REQ-015 SHALL have port RegWrite, output, 1, registered gated register write.
REQ-016 SHALL have port MemWrite, output, 1, registered gated memory write.
REQ-017 SHALL have port ValidOut, output, 1, registered instruction-present indicator for the next stage.

Function
REQ-018 SHALL define accept = Valid & ~Stall & ~Flush, and exec = accept & CondEx.
REQ-019 SHALL present Flags directly from the flags register, with no combinational path from ALUFlags.
REQ-020 SHALL, on exec & FlagW[1], load N and Z from ALUFlags at the clock edge.
REQ-021 SHALL, on exec & FlagW[0], load C and V from ALUFlags at the clock edge.
REQ-022 SHALL keep all flag bits whose write-enable bit is 0 unchanged.
REQ-023 SHALL, when accept is high, register the following one cycle later:
- PCSrc = PCS & CondEx
- RegWrite = RegW & CondEx & ~NoWrite
- MemWrite = MemW & CondEx
- ValidOut = 1
REQ-024 SHALL, when Valid = 0 and neither Stall nor Flush is high, register PCSrc, RegWrite, MemWrite and ValidOut as 0.
REQ-025 SHALL, when Stall = 1 and Flush = 0, hold the flags and all registered outputs unchanged.
REQ-026 SHALL give Flush priority over Stall: the registered outputs clear to 0 and the flags do not update.
REQ-027 SHALL apply a failed condition (CondEx = 0) as a bubble: no flag update, all writes 0, ValidOut = 1.
REQ-028 SHALL make a flag update from instruction i visible on Flags in the cycle after i is accepted, so instruction i+1 sees the new flags (back-to-back dependency).

Reset
REQ-029 SHALL, while rst_n = 0, force Flags to 4'b0000 and PCSrc, RegWrite, MemWrite and ValidOut to 0, independent of clk.
REQ-030 SHALL, on a reset mid-stall or mid-flush, discard the pending state, and SHALL accept the first instruction on the first rising edge after rst_n deasserts.

Configuration
REQ-031 SHALL, with COND_STATS_EN defined, add outputs ExecCnt[15:0] and SquashCnt[15:0].
- ExecCnt increments on exec; SquashCnt increments on accept & ~CondEx.
- Both saturate at 16'hFFFF and reset to 0.
REQ-032 SHALL, without COND_STATS_EN, omit those ports and counters entirely, with behaviour otherwise identical.

Verification
REQ-033 SHALL cover: reset asserted mid-run with Flags=4'b1111 -> Flags=4'b0000 and all outputs 0 immediately, without waiting for a clock edge.
REQ-034 SHALL cover: Valid=1, CondEx=1, FlagW=2'b10, ALUFlags=4'b1111, stored 4'b0000 -> next cycle Flags=4'b0101 (N,Z set; C,V held).
REQ-035 SHALL cover: Valid=1, CondEx=0, RegW=1, MemW=1, PCS=1, FlagW=2'b11 -> next cycle all writes 0, ValidOut=1, Flags unchanged.
REQ-036 SHALL cover: RegW=1, NoWrite=1, CondEx=1, FlagW=2'b11, ALUFlags=4'b0001 -> RegWrite=0 and Flags=4'b0001.
REQ-037 SHALL cover: Stall=1 and Flush=1 together, with prior outputs RegWrite=1 -> next cycle outputs 0 and flags unchanged; Stall alone -> outputs and flags held for 3 cycles.
REQ-038 SHALL cover, with COND_STATS_EN: 70000 accepted passing instructions -> ExecCnt=16'hFFFF and SquashCnt=0.
